credit_sender: RTL
==================

# credit_sender

Transmit end of the credit-based push link: accepts data from an upstream valid/ready source and forwards it on `push_valid`/`push_data` only while a credit is held. Credits are returned one per cycle on `push_credit` and are seeded from `credit_initial` during link reset. It pairs with `credit_receiver` across a link where either end may be in reset independently, and exchanges reset status with the far end.

## Interface
- `DATA_WIDTH`, 8, payload width.
- `MAX_CREDITS`, 4, counter ceiling (>=1).
- `CREDIT_WIDTH`, `$clog2(MAX_CREDITS+1)`, width of the credit count.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  upstream data valid.
- `in_ready`  output  1  upstream accept; a transfer occurs when `in_valid & in_ready`.
- `in_data`  input  DATA_WIDTH  upstream payload.
- `push_valid`  output  1  registered link valid.
- `push_data`  output  DATA_WIDTH  registered link payload.
- `push_credit`  input  1  one credit returned by the receiver.
- `push_credit_stall`  output  1  asks the receiver to hold credit returns.
- `push_sender_in_reset`  output  1  this end is resetting or not yet active.
- `push_receiver_in_reset`  input  1  far end is in reset.
- `credit_initial`  input  CREDIT_WIDTH  credits loaded while not ACTIVE; values above MAX_CREDITS saturate to MAX_CREDITS.
- `credit_withhold`  input  CREDIT_WIDTH  credits kept in reserve and never spent.
- `credit_count`  output  CREDIT_WIDTH  current credits held.
- `credit_available`  output  1  `credit_count > credit_withhold`.
- `credit_overflow`  output  1  sticky credit-overflow error (see Configuration).

## Operation
- FSM states: RESET, SYNC, ACTIVE. Asynchronous `rst` forces RESET.
- RESET: on the first edge with `rst` low, go to SYNC.
- SYNC: while `push_receiver_in_reset` is 1, stay in SYNC. Otherwise go to ACTIVE.
- ACTIVE: if `push_receiver_in_reset` goes to 1, return to SYNC. In the same edge, clear `push_valid` and drop any in-flight beat.
- Outside ACTIVE:
  - `credit_count` loads the saturated `credit_initial` every cycle.
  - `push_credit` is ignored.
  - `in_ready` = 0.
  - `push_credit_stall` = 1.
  - `push_sender_in_reset` = 1.
- In ACTIVE:
  - `push_sender_in_reset` = 0 and `push_credit_stall` = 0.
  - `in_ready` = `credit_available` (combinational).
  - Let send = `in_valid & in_ready`.
  - `credit_count` next = count + `push_credit` − send.
  - Simultaneous credit return and send leaves the count unchanged.
  - A `push_credit` with count == MAX_CREDITS and no send saturates at MAX_CREDITS and is flagged as an overflow.
- Count never underflows: send requires count > withhold >= 0.
- Withhold is evaluated live each cycle. Raising it above the count stops traffic with no loss of credits.

## Timing
- Reset values:
  - state RESET, `credit_count` 0, `push_valid` 0, `push_data` 0.
  - `push_sender_in_reset` 1, `push_credit_stall` 1.
  - `in_ready` 0, `credit_available` 0, `credit_overflow` 0.
- Minimum path after `rst` deasserts: RESET → SYNC on edge 1, ACTIVE on edge 2 (if the receiver is out of reset). The first beat can be accepted in the cycle after edge 2.
- Link latency: one cycle. A beat accepted at edge N appears on `push_valid`/`push_data` after edge N.
- `push_valid` is 1 for exactly one cycle per accepted beat. `push_data` holds its last value when idle.
- A credit returned at edge N is usable for a send in the cycle after edge N. Back-to-back sends sustain one per cycle while credits last.
- `rst` mid-burst: `push_valid` drops to 0 immediately (asynchronous) and all credits are lost.

## Configuration
- `CREDIT_SENDER_OVERFLOW_CHECK_EN`
  - Defined: `credit_overflow` sets on any overflow event and clears only on `rst`.
  - Undefined: the overflow logic is removed and `credit_overflow` is tied to 0. Saturation behaviour is unchanged.

## Test plan
- Reset release, `credit_initial`=2, receiver out of reset → ACTIVE after 2 edges; `credit_count`=2, `push_sender_in_reset`=0, `push_credit_stall`=0.
- 3 back-to-back beats 0x11, 0x22, 0x33 with 2 credits and no returns → 0x11 and 0x22 sent on consecutive cycles; `in_ready`=0 on the third; one `push_credit` → 0x33 sent 1 cycle later; count ends at 0.
- Count 1, `push_credit`=1 and a send in the same cycle → count stays 1 and `push_valid`=1 next cycle.
- `credit_withhold`=1 with count 1 → `credit_available`=0, `in_ready`=0, no send; withhold back to 0 → send resumes.
- `push_receiver_in_reset` pulse in ACTIVE with count 3 and `credit_initial`=1 → SYNC; `push_valid`=0 and `push_credit_stall`=1; count reloads to 1; ACTIVE resumes 1 edge after the pulse ends.
- `MAX_CREDITS`=4, count 4, `push_credit`=1 with no send → count stays 4; `credit_overflow`=1 if the macro is defined, else 0.

Source files
------------

// File: rtl/credit_sender.sv
// credit_sender: transmit end of a credit-based push link.
// Forwards upstream valid/ready beats onto a registered push link while a
// spendable credit is held; credits are seeded from i_credit_initial while
// the link is not active and returned one per cycle on i_push_credit.
// Optional feature macro: CREDIT_SENDER_OVERFLOW_CHECK_EN enables the sticky
// o_credit_overflow flag (otherwise that output is tied low).
module credit_sender #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_CREDITS  = 4,
    parameter int unsigned CREDIT_WIDTH = $clog2(MAX_CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [DATA_WIDTH-1:0]   i_in_data,
    output logic                    o_push_valid,
    output logic [DATA_WIDTH-1:0]   o_push_data,
    input  logic                    i_push_credit,
    output logic                    o_push_credit_stall,
    output logic                    o_push_sender_in_reset,
    input  logic                    i_push_receiver_in_reset,
    input  logic [CREDIT_WIDTH-1:0] i_credit_initial,
    input  logic [CREDIT_WIDTH-1:0] i_credit_withhold,
    output logic [CREDIT_WIDTH-1:0] o_credit_count,
    output logic                    o_credit_available,
    output logic                    o_credit_overflow
);

    localparam logic [CREDIT_WIDTH-1:0] LP_MAX_CREDITS = CREDIT_WIDTH'(MAX_CREDITS);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_active;
    logic                    w_leave;
    logic                    w_in_ready;
    logic                    w_stall;
    logic                    w_sender_in_reset;
    logic                    w_credit_available;
    logic                    w_send;
    logic [CREDIT_WIDTH-1:0] w_credit_init_sat;
    logic [CREDIT_WIDTH-1:0] w_count_nxt;
    logic [CREDIT_WIDTH-1:0] r_credit_count;
    logic                    r_push_valid;
    logic [DATA_WIDTH-1:0]   r_push_data;

    // Withhold is compared live so raising it gates traffic immediately.
    assign w_credit_available = (r_credit_count > i_credit_withhold);

    // Initial credit value clamped to the counter ceiling.
    assign w_credit_init_sat = (i_credit_initial > LP_MAX_CREDITS) ? LP_MAX_CREDITS
                                                                   : i_credit_initial;

    assign w_send = i_in_valid & w_in_ready;

    // Link state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state link controls.
    always_comb begin
        w_state_nxt       = r_state;
        w_active          = 1'b0;
        w_leave           = 1'b0;
        w_in_ready        = 1'b0;
        w_stall           = 1'b1;
        w_sender_in_reset = 1'b1;
        unique case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!i_push_receiver_in_reset) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_active          = 1'b1;
                w_in_ready        = w_credit_available;
                w_stall           = 1'b0;
                w_sender_in_reset = 1'b0;
                if (i_push_receiver_in_reset) begin
                    w_state_nxt = ST_SYNC;
                    w_leave     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // Credit count update: reload while inactive, otherwise return minus spend.
    always_comb begin
        w_count_nxt = r_credit_count;
        if (!w_active) begin
            w_count_nxt = w_credit_init_sat;
        end else begin
            unique case ({i_push_credit, w_send})
                2'b10: begin
                    if (r_credit_count < LP_MAX_CREDITS) begin
                        w_count_nxt = r_credit_count + CREDIT_WIDTH'(1);
                    end
                end
                2'b01: begin
                    w_count_nxt = r_credit_count - CREDIT_WIDTH'(1);
                end
                default: begin
                    w_count_nxt = r_credit_count;
                end
            endcase
        end
    end

    // Credit counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_count <= '0;
        end else begin
            r_credit_count <= w_count_nxt;
        end
    end

    // Push link register; a beat taken on the edge that leaves ACTIVE is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
        end else begin
            r_push_valid <= w_send & ~w_leave;
            if (w_send && !w_leave) begin
                r_push_data <= i_in_data;
            end
        end
    end

`ifdef CREDIT_SENDER_OVERFLOW_CHECK_EN
    logic w_overflow_event;
    logic r_credit_overflow;

    // A return that would push the count past the ceiling.
    assign w_overflow_event = w_active & i_push_credit & ~w_send
                              & (r_credit_count >= LP_MAX_CREDITS);

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_overflow <= 1'b0;
        end else if (w_overflow_event) begin
            r_credit_overflow <= 1'b1;
        end
    end

    assign o_credit_overflow = r_credit_overflow;
`else
    assign o_credit_overflow = 1'b0;
`endif

    assign o_in_ready             = w_in_ready;
    assign o_push_valid           = r_push_valid;
    assign o_push_data            = r_push_data;
    assign o_push_credit_stall    = w_stall;
    assign o_push_sender_in_reset = w_sender_in_reset;
    assign o_credit_count         = r_credit_count;
    assign o_credit_available     = w_credit_available;

endmodule
